fu_completion_unit: RTL and testbench

// - Receiving end of the FU result interface. Collects fu_out_valid/fu_out_inst_id and PRF write ports from all FU_COUNT FU wrappers.
// - Broadcasts same-cycle PRN wakeups (set_prn/set_prn_ready) back to every issue queue.
// - Buffers completions in one FIFO per FU. Drains them round-robin, one per cycle, to the ROB completion port with a valid/ready handshake.

---
 rtl/fu_completion_unit.sv | 163 ++++++++++++++++
 tb/tb_fu_completion_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fu_completion_unit.sv
// FU completion unit: same-cycle PRN wakeup broadcast plus per-FU completion
// FIFOs drained round-robin into the ROB completion port.
module fu_completion_unit #(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int FU_COUNT     = 4,
    parameter int FIFO_DEPTH   = 4,
    localparam int FUC_BITS    = $clog2(FU_COUNT)
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             flush,
    input  logic [FU_COUNT-1:0]                              fu_out_valid,
    input  logic [FU_COUNT-1:0][INST_ID_BITS-1:0]            fu_out_inst_id,
    input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]            prf_write_enable,
    input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] prf_write_prn,
    output logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]            set_prn_ready,
    output logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] set_prn,
    output logic [FU_COUNT-1:0]                              fu_stall,
    output logic                                             rob_complete_valid,
    input  logic                                             rob_complete_ready,
    output logic [INST_ID_BITS-1:0]                          rob_complete_inst_id,
    output logic [FUC_BITS-1:0]                              rob_complete_fu,
    output logic                                             overflow_err,
    output logic [FUC_BITS-1:0]                              overflow_fu,
    output logic                                             all_empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [INST_ID_BITS-1:0] mem    [FU_COUNT][FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr [FU_COUNT];
    logic [PTR_W-1:0]        wr_ptr [FU_COUNT];
    logic [CNT_W-1:0]        count  [FU_COUNT];

    logic                clr;
    logic [FU_COUNT-1:0] not_empty;
    logic [FU_COUNT-1:0] push_ok;
    logic [FU_COUNT-1:0] pop;
    logic [FU_COUNT-1:0] drop;
    logic [FUC_BITS-1:0] rr_ptr;
    logic [FUC_BITS-1:0] scan_sel;
    logic [FUC_BITS-1:0] cand;
    logic [FUC_BITS-1:0] sel;
    logic [FUC_BITS-1:0] lock_sel;
    logic [FUC_BITS-1:0] first_drop;
    logic                locked;
    logic                found;
    logic                handshake;

    assign clr = rst | flush;

    // Wakeup broadcast: pure pass-through, never blocked by FIFO state.
    always_comb begin
        set_prn       = prf_write_prn;
        set_prn_ready = '0;
        for (int i = 0; i < FU_COUNT; i++) begin
            for (int j = 0; j < MAX_OPERANDS; j++) begin
                set_prn_ready[i][j] = fu_out_valid[i] & prf_write_enable[i][j] & ~rst;
            end
        end
    end

    // Status flags derived from the registered counts.
    always_comb begin
        not_empty = '0;
        fu_stall  = '0;
        for (int i = 0; i < FU_COUNT; i++) begin
            not_empty[i] = (count[i] != '0);
            fu_stall[i]  = (count[i] >= CNT_W'(FIFO_DEPTH - 1));
        end
    end

    assign all_empty = ~|not_empty;

    // Round-robin scan; a pending-but-unaccepted completion keeps its FIFO locked.
    always_comb begin
        scan_sel = '0;
        cand     = '0;
        found    = 1'b0;
        for (int k = 0; k < FU_COUNT; k++) begin
            cand = FUC_BITS'((int'(rr_ptr) + k) % FU_COUNT);
            if (!found && not_empty[cand]) begin
                scan_sel = cand;
                found    = 1'b1;
            end
        end
        sel                  = locked ? lock_sel : scan_sel;
        rob_complete_valid   = |not_empty;
        rob_complete_inst_id = rob_complete_valid ? mem[sel][rd_ptr[sel]] : '0;
        rob_complete_fu      = rob_complete_valid ? sel : '0;
        handshake            = rob_complete_valid & rob_complete_ready;
    end

    // Push acceptance and drop detection; a pop in the same cycle frees a slot.
    always_comb begin
        pop        = '0;
        push_ok    = '0;
        drop       = '0;
        first_drop = '0;
        for (int i = 0; i < FU_COUNT; i++) begin
            pop[i]     = handshake && (sel == FUC_BITS'(i));
            push_ok[i] = fu_out_valid[i] && !clr &&
                         ((count[i] < CNT_W'(FIFO_DEPTH)) || pop[i]);
            drop[i]    = fu_out_valid[i] && !clr && !push_ok[i];
        end
        for (int i = FU_COUNT - 1; i >= 0; i--) begin
            if (drop[i]) first_drop = FUC_BITS'(i);
        end
    end

    // FIFO storage writes; contents need no reset since counts gate visibility.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FU_COUNT; i++) begin
            if (push_ok[i]) mem[i][wr_ptr[i]] <= fu_out_inst_id[i];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FU_COUNT; i++) begin
            if (clr) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end else begin
                if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])     rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (push_ok[i] && !pop[i])      count[i] <= count[i] + 1'b1;
                else if (pop[i] && !push_ok[i]) count[i] <= count[i] - 1'b1;
            end
        end
    end

    // Arbiter pointer and output lock.
    always_ff @(posedge clk) begin
        if (clr) begin
            rr_ptr   <= '0;
            locked   <= 1'b0;
            lock_sel <= '0;
        end else if (handshake) begin
            rr_ptr   <= FUC_BITS'((int'(sel) + 1) % FU_COUNT);
            locked   <= 1'b0;
        end else if (rob_complete_valid) begin
            locked   <= 1'b1;
            lock_sel <= sel;
        end
    end

    // Sticky overflow report; survives flush so software can still see it.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_err <= 1'b0;
            overflow_fu  <= '0;
        end else if (|drop) begin
            overflow_err <= 1'b1;
            if (!overflow_err) overflow_fu <= first_drop;
        end
    end

endmodule

// File: tb/tb_fu_completion_unit.sv
// Scoreboard bench for fu_completion_unit.
module tb_fu_completion_unit;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic [3:0]             fu_out_valid;
    logic [3:0][5:0]        fu_out_inst_id;
    logic [3:0][2:0]        prf_write_enable;
    logic [3:0][2:0][5:0]   prf_write_prn;
    logic [3:0][2:0]        set_prn_ready;
    logic [3:0][2:0][5:0]   set_prn;
    logic [3:0]             fu_stall;
    logic                   rob_complete_valid;
    logic                   rob_complete_ready;
    logic [5:0]             rob_complete_inst_id;
    logic [1:0]             rob_complete_fu;
    logic                   overflow_err;
    logic [1:0]             overflow_fu;
    logic                   all_empty;

    typedef struct {
        int id;
        int fu;
    } comp_t;

    comp_t sb[$];
    int    checks = 0;
    int    errors = 0;
    logic  mon_en = 1'b0;

    fu_completion_unit dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush                (flush),
        .fu_out_valid         (fu_out_valid),
        .fu_out_inst_id       (fu_out_inst_id),
        .prf_write_enable     (prf_write_enable),
        .prf_write_prn        (prf_write_prn),
        .set_prn_ready        (set_prn_ready),
        .set_prn              (set_prn),
        .fu_stall             (fu_stall),
        .rob_complete_valid   (rob_complete_valid),
        .rob_complete_ready   (rob_complete_ready),
        .rob_complete_inst_id (rob_complete_inst_id),
        .rob_complete_fu      (rob_complete_fu),
        .overflow_err         (overflow_err),
        .overflow_fu          (overflow_fu),
        .all_empty            (all_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every accepted completion must match the next scoreboard entry.
    always @(negedge clk) begin
        if (mon_en && !rst && rob_complete_valid && rob_complete_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", int'(rob_complete_inst_id), -1);
            end else begin
                comp_t e;
                e = sb.pop_front();
                chk("sb_id", int'(rob_complete_inst_id), e.id);
                chk("sb_fu", int'(rob_complete_fu), e.fu);
            end
        end
    end

    task automatic push_exp(input int id, input int fu);
        comp_t e;
        e.id = id;
        e.fu = fu;
        sb.push_back(e);
    endtask

    task automatic do_flush();
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk); #1 rob_complete_ready = r;
    endtask

    task automatic wait_empty(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!all_empty && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, int'(all_empty), 1);
        chk({tag, "_sb"}, sb.size(), 0);
    endtask

    initial begin
        rst                = 1'b1;
        flush              = 1'b0;
        fu_out_valid       = '0;
        fu_out_inst_id     = '0;
        prf_write_enable   = '0;
        prf_write_prn      = '0;
        rob_complete_ready = 1'b0;

        // Reset held two cycles
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", int'(rob_complete_valid), 0);
        chk("rst_empty", int'(all_empty), 1);
        chk("rst_stall", int'(fu_stall), 0);
        chk("rst_ovf", int'(overflow_err), 0);
        chk("rst_id", int'(rob_complete_inst_id), 0);
        mon_en = 1'b1;

        // Wakeup is same-cycle; the completion itself drains later
        set_ready(1'b1);
        @(negedge clk);
        fu_out_valid           = 4'b0100;
        fu_out_inst_id[2]      = 6'd11;
        prf_write_enable[2]    = 3'b001;
        prf_write_prn[2][0]    = 6'd17;
        prf_write_prn[2][1]    = 6'd5;
        push_exp(11, 2);
        #1;
        chk("wake_rdy", int'(set_prn_ready), 12'h040);
        chk("wake_prn", int'(set_prn[2][0]), 17);
        chk("wake_prn1", int'(set_prn[2][1]), 5);
        @(posedge clk); #1;
        fu_out_valid     = '0;
        prf_write_enable = '0;
        #1 chk("wake_idle", int'(set_prn_ready), 0);
        wait_empty("wake_drain");

        // Latency and round robin from rr_ptr = 0
        do_flush();
        @(negedge clk);
        fu_out_valid      = 4'b1001;
        fu_out_inst_id[0] = 6'd5;
        fu_out_inst_id[3] = 6'd9;
        push_exp(5, 0);
        push_exp(9, 3);
        #1 chk("lat_t0", int'(rob_complete_valid), 0);
        @(posedge clk); #1 fu_out_valid = '0;
        @(negedge clk);
        chk("rr_c1_fu", int'(rob_complete_fu), 0);
        @(negedge clk);
        chk("rr_c2_fu", int'(rob_complete_fu), 3);
        @(negedge clk);
        chk("rr_c3_valid", int'(rob_complete_valid), 0);
        chk("rr_sb", sb.size(), 0);

        // Output stays locked while the ROB stalls
        do_flush();
        set_ready(1'b0);
        @(negedge clk);
        fu_out_valid      = 4'b0100;
        fu_out_inst_id[2] = 6'd7;
        @(posedge clk); #1 fu_out_valid = '0;
        @(negedge clk);
        chk("lock_valid", int'(rob_complete_valid), 1);
        chk("lock_id0", int'(rob_complete_inst_id), 7);
        chk("lock_fu0", int'(rob_complete_fu), 2);
        fu_out_valid      = 4'b0001;
        fu_out_inst_id[0] = 6'd3;
        @(posedge clk); #1 fu_out_valid = '0;
        repeat (2) begin
            @(negedge clk);
            chk("lock_id", int'(rob_complete_inst_id), 7);
            chk("lock_fu", int'(rob_complete_fu), 2);
        end
        push_exp(7, 2);
        push_exp(3, 0);
        set_ready(1'b1);
        wait_empty("lock_drain");

        // Overflow: five back-to-back pushes into FU1 with ROB stalled
        do_flush();
        set_ready(1'b0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            fu_out_valid      = 4'b0010;
            fu_out_inst_id[1] = 6'(20 + k);
            if (k < 4) push_exp(20 + k, 1);
            @(posedge clk); #1 fu_out_valid = '0;
            @(negedge clk);
            chk("ovf_stall", int'(fu_stall[1]), (k >= 2) ? 1 : 0);
            chk("ovf_err", int'(overflow_err), (k == 4) ? 1 : 0);
        end
        chk("ovf_fu", int'(overflow_fu), 1);
        set_ready(1'b1);
        wait_empty("ovf_drain");
        chk("ovf_sticky", int'(overflow_err), 1);

        // Flush discards queued entries but keeps the overflow record
        set_ready(1'b0);
        @(negedge clk);
        fu_out_valid      = 4'b1011;
        fu_out_inst_id[0] = 6'd30;
        fu_out_inst_id[1] = 6'd31;
        fu_out_inst_id[3] = 6'd32;
        @(posedge clk); #1 fu_out_valid = '0;
        @(negedge clk);
        chk("fl_pre_empty", int'(all_empty), 0);
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("fl_empty", int'(all_empty), 1);
        chk("fl_valid", int'(rob_complete_valid), 0);
        chk("fl_ovf", int'(overflow_err), 1);
        chk("fl_ovf_fu", int'(overflow_fu), 1);

        // Reset clears the sticky overflow
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst2_ovf", int'(overflow_err), 0);
        chk("rst2_ovf_fu", int'(overflow_fu), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
